// File: rtl/cv32e40p_tmr_fault_manager.sv
// Triple-modular-redundancy voter with per-replica error accounting, a
// resync request/acknowledge handshake and a sticky multi-replica fatal state.
module cv32e40p_tmr_fault_manager #(
  parameter int unsigned NCH            = 4,
  parameter int unsigned CH_W           = 32,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned CONSEC_TH      = 3,
  parameter int unsigned RECOVER_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*CH_W-1:0]  replica_a_i,
  input  logic [NCH*CH_W-1:0]  replica_b_i,
  input  logic [NCH*CH_W-1:0]  replica_c_i,
  output logic [NCH*CH_W-1:0]  data_o,
  output logic [NCH-1:0]       error_voter_o,
  output logic [2:0]           replica_err_o,
  output logic [3*CNT_W-1:0]   err_cnt_o,
  input  logic                 clear_cnt_i,
  output logic                 resync_req_o,
  input  logic                 resync_ack_i,
  output logic [1:0]           faulty_replica_o,
  output logic                 fatal_o
);

  localparam int unsigned W  = NCH * CH_W;
  localparam int unsigned CW = $clog2(CONSEC_TH + 1);
  localparam int unsigned RW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_RECOVER = 2'd2;
  localparam logic [1:0] S_FATAL   = 2'd3;

  localparam logic [1:0]       NO_REPLICA = 2'd3;
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CW-1:0]    TH_V       = CW'(CONSEC_TH);
  localparam logic [RW-1:0]    REC_LOAD   = RW'(RECOVER_CYCLES - 1);

  logic [W-1:0]     vote_s;
  logic [W-1:0]     diff_all_s;
  logic [2:0]       rerr_s;
  logic             multi_s;
  logic             single_s;
  logic [1:0]       single_id_s;

  logic [1:0]       state_q, state_d;
  logic [RW-1:0]    rec_cnt_q, rec_cnt_d;
  logic [CW-1:0]    consec_cnt_q, consec_cnt_d, consec_next_s;
  logic [1:0]       consec_id_q, consec_id_d;
  logic [1:0]       faulty_q, faulty_d;
  logic             req_q, fatal_q;
  logic [CNT_W-1:0] err_cnt_q [3];
  logic [CNT_W-1:0] err_cnt_d [3];

  assign vote_s     = (replica_a_i & replica_b_i) | (replica_a_i & replica_c_i) |
                      (replica_b_i & replica_c_i);
  assign diff_all_s = (replica_a_i ^ vote_s) | (replica_b_i ^ vote_s) | (replica_c_i ^ vote_s);

  assign rerr_s[0] = |(replica_a_i ^ vote_s);
  assign rerr_s[1] = |(replica_b_i ^ vote_s);
  assign rerr_s[2] = |(replica_c_i ^ vote_s);

  assign multi_s  = (rerr_s[0] & rerr_s[1]) | (rerr_s[0] & rerr_s[2]) | (rerr_s[1] & rerr_s[2]);
  assign single_s = (|rerr_s) & ~multi_s;

  // Per-channel disagreement flags and the index of a lone offending replica.
  always_comb begin
    error_voter_o = '0;
    for (int k = 0; k < NCH; k++) begin
      error_voter_o[k] = |diff_all_s[k*CH_W +: CH_W];
    end
    if (rerr_s[0]) begin
      single_id_s = 2'd0;
    end else if (rerr_s[1]) begin
      single_id_s = 2'd1;
    end else begin
      single_id_s = 2'd2;
    end
  end

  // Saturating error-cycle counters; clear wins over increment.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      if (clear_cnt_i) begin
        err_cnt_d[r] = '0;
      end else if (rerr_s[r] && (err_cnt_q[r] != CNT_MAX)) begin
        err_cnt_d[r] = err_cnt_q[r] + CNT_W'(1);
      end else begin
        err_cnt_d[r] = err_cnt_q[r];
      end
    end
  end

  // Consecutive single-replica tracker and handshake FSM next state.
  always_comb begin
    state_d     = state_q;
    rec_cnt_d   = rec_cnt_q;
    faulty_d    = faulty_q;
    consec_id_d = consec_id_q;

    if ((state_q == S_IDLE) && single_s) begin
      consec_id_d = single_id_s;
      if (single_id_s == consec_id_q) begin
        consec_next_s = consec_cnt_q + CW'(1);
      end else begin
        consec_next_s = CW'(1);
      end
    end else begin
      consec_next_s = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (consec_next_s == TH_V) begin
          state_d  = S_REQ;
          faulty_d = single_id_s;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_REQ: begin
        if (resync_ack_i) begin
          state_d   = S_RECOVER;
          rec_cnt_d = REC_LOAD;
        end else begin
          state_d   = S_REQ;
        end
      end
      S_RECOVER: begin
        if (rec_cnt_q == '0) begin
          state_d  = S_IDLE;
          faulty_d = NO_REPLICA;
        end else begin
          rec_cnt_d = rec_cnt_q - RW'(1);
        end
      end
      S_FATAL: begin
        state_d = S_FATAL;
      end
      default: begin
        state_d  = S_FATAL;
        faulty_d = NO_REPLICA;
      end
    endcase

    // A multi-replica disagreement overrides any handshake progress.
    if (multi_s) begin
      state_d  = S_FATAL;
      faulty_d = NO_REPLICA;
    end else begin
      state_d  = state_d;
    end

    if ((state_q == S_IDLE) && (state_d == S_IDLE)) begin
      consec_cnt_d = consec_next_s;
    end else begin
      consec_cnt_d = '0;
    end
  end

  // State, tracker, counter and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rec_cnt_q    <= '0;
      consec_cnt_q <= '0;
      consec_id_q  <= NO_REPLICA;
      faulty_q     <= NO_REPLICA;
      req_q        <= 1'b0;
      fatal_q      <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        err_cnt_q[r] <= '0;
      end
    end else begin
      state_q      <= state_d;
      rec_cnt_q    <= rec_cnt_d;
      consec_cnt_q <= consec_cnt_d;
      consec_id_q  <= consec_id_d;
      faulty_q     <= faulty_d;
      req_q        <= (state_d == S_REQ);
      fatal_q      <= (state_d == S_FATAL);
      for (int r = 0; r < 3; r++) begin
        err_cnt_q[r] <= err_cnt_d[r];
      end
    end
  end

  assign data_o           = vote_s;
  assign replica_err_o    = rerr_s;
  assign err_cnt_o        = {err_cnt_q[2], err_cnt_q[1], err_cnt_q[0]};
  assign resync_req_o     = req_q;
  assign faulty_replica_o = faulty_q;
  assign fatal_o          = fatal_q;

endmodule

// File: tb/tb_cv32e40p_tmr_fault_manager.sv
// Directed scoreboard bench for the TMR voter and resync/fatal handshake.
module tb_cv32e40p_tmr_fault_manager;

  localparam int NCH   = 4;
  localparam int CH_W  = 32;
  localparam int CNT_W = 8;
  localparam int W     = NCH * CH_W;

  logic                 clk;
  logic                 rst_n;
  logic [W-1:0]         ra, rb, rc;
  logic [W-1:0]         data_o;
  logic [NCH-1:0]       error_voter_o;
  logic [2:0]           replica_err_o;
  logic [3*CNT_W-1:0]   err_cnt_o;
  logic                 clear_cnt_i;
  logic                 resync_req_o;
  logic                 resync_ack_i;
  logic [1:0]           faulty_replica_o;
  logic                 fatal_o;

  cv32e40p_tmr_fault_manager #(
    .NCH(NCH), .CH_W(CH_W), .CNT_W(CNT_W), .CONSEC_TH(3), .RECOVER_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .replica_a_i(ra), .replica_b_i(rb), .replica_c_i(rc),
    .data_o(data_o), .error_voter_o(error_voter_o), .replica_err_o(replica_err_o),
    .err_cnt_o(err_cnt_o), .clear_cnt_i(clear_cnt_i),
    .resync_req_o(resync_req_o), .resync_ack_i(resync_ack_i),
    .faulty_replica_o(faulty_replica_o), .fatal_o(fatal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]       data;
    logic [NCH-1:0]     voter;
    logic [2:0]         rerr;
    logic [3*CNT_W-1:0] cnt;
    logic               req;
    logic [1:0]         faulty;
    logic               fatal;
  } exp_t;

  exp_t             sbq[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] cnt_m [3];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, queue expectations, compare at the falling edge.
  task automatic cyc(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                     input logic clr, input logic ack, input logic exp_req,
                     input logic [1:0] exp_faulty, input logic exp_fatal, input string tag);
    exp_t         e;
    exp_t         got;
    logic [W-1:0] maj;
    @(posedge clk);
    #1;
    ra = a; rb = b; rc = c; clear_cnt_i = clr; resync_ack_i = ack;
    maj = (a & b) | (a & c) | (b & c);
    e.data = maj;
    for (int k = 0; k < NCH; k++) begin
      e.voter[k] = (a[k*CH_W +: CH_W] !== maj[k*CH_W +: CH_W]) ||
                   (b[k*CH_W +: CH_W] !== maj[k*CH_W +: CH_W]) ||
                   (c[k*CH_W +: CH_W] !== maj[k*CH_W +: CH_W]);
    end
    e.rerr   = {c !== maj, b !== maj, a !== maj};
    e.cnt    = {cnt_m[2], cnt_m[1], cnt_m[0]};
    e.req    = exp_req;
    e.faulty = exp_faulty;
    e.fatal  = exp_fatal;
    sbq.push_back(e);
    @(negedge clk);
    got = sbq.pop_front();
    chk({tag, "_data"},   data_o,           got.data);
    chk({tag, "_voter"},  error_voter_o,    got.voter);
    chk({tag, "_rerr"},   replica_err_o,    got.rerr);
    chk({tag, "_cnt"},    err_cnt_o,        got.cnt);
    chk({tag, "_req"},    resync_req_o,     got.req);
    chk({tag, "_faulty"}, faulty_replica_o, got.faulty);
    chk({tag, "_fatal"},  fatal_o,          got.fatal);
    for (int r = 0; r < 3; r++) begin
      if (clr) cnt_m[r] = '0;
      else if (got.rerr[r] && cnt_m[r] != 8'hFF) cnt_m[r] = cnt_m[r] + 8'd1;
    end
  endtask

  logic [W-1:0] base;
  logic [W-1:0] one;

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    ra = base; rb = base; rc = base ^ (one << 7);
    clear_cnt_i = 1'b0; resync_ack_i = 1'b0;
    #1;
    chk({tag, "_rst_req"},    resync_req_o,     1'b0);
    chk({tag, "_rst_fatal"},  fatal_o,          1'b0);
    chk({tag, "_rst_faulty"}, faulty_replica_o, 2'd3);
    chk({tag, "_rst_cnt"},    err_cnt_o,        24'd0);
    chk({tag, "_rst_data"},   data_o,           base);
    chk({tag, "_rst_rerr"},   replica_err_o,    3'b100);
    rc = base;
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 3; r++) cnt_m[r] = '0;
  endtask

  initial begin
    logic [W-1:0] bad_a0, bad_b5, bad_b_ch2, bad_c;
    one  = 1;
    base = {NCH{32'hDEADBEEF}};
    bad_a0    = base ^ one;
    bad_b5    = base ^ (one << 5);
    bad_b_ch2 = base ^ (one << (2 * CH_W + 3));
    bad_c     = base ^ (one << 100);
    rst_n = 1'b1;
    ra = base; rb = base; rc = base; clear_cnt_i = 1'b0; resync_ack_i = 1'b0;

    do_reset("r0");

    // Clean voting.
    for (int i = 0; i < 3; i++) cyc(base, base, base, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, "clean");
    chk("clean_data_const", data_o, {NCH{32'hDEADBEEF}});

    // Single-bit flip of B in channel 2.
    cyc(base, bad_b_ch2, base, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, "flipb");
    chk("flipb_voter_const", error_voter_o, 4'b0100);
    chk("flipb_rerr_const",  replica_err_o, 3'b010);
    cyc(base, base, base, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, "flipb_after");
    chk("flipb_cntb_const", err_cnt_o[2*CNT_W-1:CNT_W], 8'd1);

    // Replica C wrong for three cycles, ack in cycle 6, back to IDLE in cycle 11.
    for (int i = 1; i <= 3; i++) cyc(base, base, bad_c, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, "c_err");
    cyc(base, base, base, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, "c4");
    cyc(base, base, base, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, "c5");
    cyc(base, base, base, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, "c6_ack");
    for (int i = 7; i <= 10; i++) cyc(base, base, base, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, "c_recover");
    cyc(base, base, base, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, "c11_idle");

    // A, A, B, B, B gives one request naming B.
    cyc(bad_a0, base, base, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, "aabbb_a");
    cyc(bad_a0, base, base, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, "aabbb_a");
    for (int i = 0; i < 3; i++) cyc(base, bad_b5, base, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, "aabbb_b");
    cyc(base, base, base, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, "aabbb_req");

    // Multi-fault while in REQ with ack high goes FATAL.
    cyc(bad_a0, bad_b5, base, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, "multi");
    cyc(base, base, base, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1, "fatal1");
    cyc(base, base, bad_c, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, "fatal2");
    cyc(base, base, base, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, "fatal3");

    // Reset leaves FATAL; then an asynchronous reset mid-request drops it at once.
    do_reset("r1");
    for (int i = 0; i < 3; i++) cyc(base, base, bad_c, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, "hs_err");
    cyc(base, base, base, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, "hs_req");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", resync_req_o, 1'b0);
    do_reset("r2");

    // Saturation of counter A, then clear together with an error.
    for (int i = 0; i < 300; i++)
      cyc(bad_a0, base, base, 1'b0, 1'b0, (i >= 3), (i >= 3) ? 2'd0 : 2'd3, 1'b0, "sat");
    chk("sat_cnta_const", err_cnt_o[CNT_W-1:0], 8'd255);
    cyc(bad_a0, base, base, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, "clr");
    cyc(base, base, base, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, "clr_after");
    chk("clr_cnta_const", err_cnt_o[CNT_W-1:0], 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
